serial_adder_ctrl: RTL and testbench

- Sequences one external single-bit full adder to add or subtract two WIDTH-bit operands bit-serially, LSB first.
- Sits between the board-level switch/key logic and a full-adder instance, so one adder cell serves a multi-bit datapath.
- Provides a start/done handshake, a busy flag, and registered result, carry-out and signed-overflow outputs.

---
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer driving one external full-adder cell.
// Operands are processed LSB first; result, carry-out and overflow are registered.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {st_idle, st_add, st_done} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    count_q, count_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             in_add;

   // Adder cell inputs kept outside the next-state block so fa_sum/fa_cout feed back cleanly.
   assign in_add = (state_q == st_add);
   assign fa_a   = in_add & a_sh_q[0];
   assign fa_b   = in_add & (b_sh_q[0] ^ sub_q);
   assign fa_cin = in_add & carry_q;

   assign busy     = in_add;
   assign done     = (state_q == st_done);
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      result_d = result_q;
      count_d  = count_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         st_idle: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               sub_d   = sub;
               carry_d = sub;
               count_d = '0;
               state_d = st_add;
            end
         end
         st_add: begin
            res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_cout;
            count_d  = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               // MSB slice: carry into vs. out of the sign bit gives signed overflow.
               result_d = res_sh_d;
               cout_d   = fa_cout;
               ovf_d    = carry_q ^ fa_cout;
               state_d  = st_done;
            end
         end
         st_done: state_d = st_idle;
         default: state_d = st_idle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= st_idle;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         result_q <= '0;
         count_q  <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         result_q <= result_d;
         count_q  <= count_d;
         sub_q    <= sub_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a behavioural full-adder cell attached.
module tb_serial_adder_ctrl;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;

   int cmp = 0;
   int bad = 0;

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow),
      .fa_a     (fa_a),
      .fa_b     (fa_b),
      .fa_cin   (fa_cin),
      .fa_sum   (fa_sum),
      .fa_cout  (fa_cout)
   );

   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      sub   = s;
      a     = x;
      b     = y;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Returns edges taken to reach done (-1 on timeout) and cycles seen with busy high.
   task automatic wait_done(output int cyc, output int bcyc);
      cyc  = 0;
      bcyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) bcyc++;
         step();
         cyc++;
      end
      if (done !== 1'b1) cyc = -1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      sub     = 1'b0;
      a       = '0;
      b       = '0;
      #12;
      cmp++;
      if ({busy, done, cout, overflow} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags got=%b want=0000", {busy, done, cout, overflow});
      end
      cmp++;
      if (result !== 8'h00) begin
         bad++;
         $display("FAIL reset_result got=%h want=00", result);
      end
      cmp++;
      if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
         bad++;
         $display("FAIL reset_fa got=%b want=000", {fa_a, fa_b, fa_cin});
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_add_basic();
      int c, bc;
      start_op(1'b0, 8'h3C, 8'h15);
      wait_done(c, bc);
      cmp++;
      if (c !== WIDTH) begin
         bad++;
         $display("FAIL add_latency got=%0d want=%0d", c, WIDTH);
      end
      cmp++;
      if (bc !== WIDTH) begin
         bad++;
         $display("FAIL add_busy_cycles got=%0d want=%0d", bc, WIDTH);
      end
      cmp++;
      if ({result, cout, overflow} !== {8'h51, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL add_3c_15 got=%h/%b/%b want=51/0/0", result, cout, overflow);
      end
      cmp++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL add_busy_in_done got=%b want=0", busy);
      end
      step();
      cmp++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL add_done_pulse got=%b want=0", done);
      end
   endtask

   task automatic test_add_wrap();
      int c, bc;
      start_op(1'b0, 8'hFF, 8'h01);
      wait_done(c, bc);
      cmp++;
      if ({result, cout, overflow} !== {8'h00, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL add_ff_01 got=%h/%b/%b want=00/1/0", result, cout, overflow);
      end
      step();
      start_op(1'b0, 8'h7F, 8'h01);
      wait_done(c, bc);
      cmp++;
      if ({result, cout, overflow} !== {8'h80, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL add_7f_01 got=%h/%b/%b want=80/0/1", result, cout, overflow);
      end
      step();
   endtask

   task automatic test_sub();
      int c, bc;
      start_op(1'b1, 8'h05, 8'h07);
      wait_done(c, bc);
      cmp++;
      if ({result, cout, overflow} !== {8'hFE, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL sub_05_07 got=%h/%b/%b want=fe/0/0", result, cout, overflow);
      end
      step();
      start_op(1'b1, 8'h80, 8'h01);
      wait_done(c, bc);
      cmp++;
      if ({result, cout, overflow} !== {8'h7F, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL sub_80_01 got=%h/%b/%b want=7f/1/1", result, cout, overflow);
      end
      step();
   endtask

   task automatic test_fa_bits();
      logic [7:0] x, y;
      logic       carry;
      logic [2:0] exp;
      x = 8'h3C;
      y = 8'h15;
      cmp++;
      if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
         bad++;
         $display("FAIL fa_idle got=%b want=000", {fa_a, fa_b, fa_cin});
      end
      start_op(1'b0, x, y);
      carry = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp = {x[i], y[i], carry};
         cmp++;
         if ({fa_a, fa_b, fa_cin} !== exp) begin
            bad++;
            $display("FAIL fa_bit%0d got=%b want=%b", i, {fa_a, fa_b, fa_cin}, exp);
         end
         carry = (x[i] & y[i]) | (x[i] & carry) | (y[i] & carry);
         step();
      end
      cmp++;
      if ({done, fa_a, fa_b, fa_cin} !== 4'b1000) begin
         bad++;
         $display("FAIL fa_done got=%b want=1000", {done, fa_a, fa_b, fa_cin});
      end
      step();
   endtask

   task automatic test_ignore();
      int c, bc;
      start_op(1'b0, 8'h3C, 8'h15);
      repeat (3) step();
      start = 1'b1;
      sub   = 1'b1;
      a     = 8'hFF;
      b     = 8'hFF;
      step();
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      wait_done(c, bc);
      cmp++;
      if (c !== 4) begin
         bad++;
         $display("FAIL ignore_latency got=%0d want=4", c);
      end
      cmp++;
      if ({result, cout, overflow} !== {8'h51, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL ignore_result got=%h/%b/%b want=51/0/0", result, cout, overflow);
      end
      step();
      // start held high all the way through DONE
      sub   = 1'b0;
      a     = 8'h7F;
      b     = 8'h01;
      start = 1'b1;
      step();
      wait_done(c, bc);
      cmp++;
      if (c !== WIDTH) begin
         bad++;
         $display("FAIL held_latency got=%0d want=%0d", c, WIDTH);
      end
      step();
      cmp++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL held_idle_busy got=%b want=0", busy);
      end
      step();
      cmp++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL held_restart_busy got=%b want=1", busy);
      end
      start = 1'b0;
      wait_done(c, bc);
      cmp++;
      if ({result, overflow} !== {8'h80, 1'b1}) begin
         bad++;
         $display("FAIL held_result got=%h/%b want=80/1", result, overflow);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int c, bc, dn;
      start_op(1'b0, 8'h3C, 8'h15);
      repeat (3) step();
      reset_n = 1'b0;
      #1;
      cmp++;
      if ({busy, done, cout, overflow} !== 4'b0000) begin
         bad++;
         $display("FAIL rstmid_flags got=%b want=0000", {busy, done, cout, overflow});
      end
      cmp++;
      if (result !== 8'h00) begin
         bad++;
         $display("FAIL rstmid_result got=%h want=00", result);
      end
      cmp++;
      if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
         bad++;
         $display("FAIL rstmid_fa got=%b want=000", {fa_a, fa_b, fa_cin});
      end
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done === 1'b1) dn++;
      end
      cmp++;
      if (dn !== 0) begin
         bad++;
         $display("FAIL rstmid_no_done got=%0d want=0", dn);
      end
      start_op(1'b0, 8'h01, 8'h01);
      wait_done(c, bc);
      cmp++;
      if ({result, cout, overflow} !== {8'h02, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL rstmid_fresh got=%h/%b/%b want=02/0/0", result, cout, overflow);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_add_wrap();
      test_sub();
      test_fa_bits();
      test_ignore();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule
